ysyx_25030077_ifu: RTL and testbench
====================================

Name: ysyx_25030077_ifu

Overview:
Instruction fetch unit for the single-issue core. Holds the architectural PC and fetches one instruction at a time over a valid/ready instruction-memory port. It presents the instruction and its PC to decode/execute, then waits for execute to commit. On commit it loads the computed next PC and starts the next fetch. It is the consumer of the next-PC value and the producer of the instruction/PC pair used by the next-PC logic.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset.
TIMEOUT, 16, maximum cycles spent in WAIT before a fault is raised; 0 disables the timeout.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
io_pc_next  in  32  next PC from execute; sampled only when io_commit=1
io_commit  in  1  execute has finished the current instruction; one-cycle pulse
io_halt  in  1  qualified by io_commit; stop fetching after this commit
io_imem_req_valid  out  1  fetch request valid
io_imem_req_ready  in  1  memory accepts the request
io_imem_req_addr  out  32  fetch address
io_imem_resp_valid  in  1  response valid
io_imem_resp_data  in  32  instruction word
io_imem_resp_err  in  1  bus error on the response
io_inst_valid  out  1  io_instruction and io_pc_count are valid for execute
io_instruction  out  32  latched instruction
io_pc_count  out  32  current PC register
io_fetch_fault  out  1  sticky fault flag
io_fault_cause  out  2  fault cause: 0 none, 1 misaligned PC, 2 bus error, 3 timeout
io_halted  out  1  sticky halt flag
io_retired  out  32  count of committed instructions

Behaviour:
- Reset (synchronous, active-high) puts the block in:
  - state FETCH, pc=RESET_PC, io_instruction=0, io_retired=0
  - io_inst_valid=0, io_fetch_fault=0, io_fault_cause=0, io_halted=0, wait counter=0
  - io_imem_req_valid=0 while reset is asserted.
- Reset asserted in any state, including mid-WAIT, returns to FETCH. A response arriving after reset deasserts is ignored unless the block has reached WAIT again.
- Continuous assignments: io_pc_count=pc and io_imem_req_addr=pc at all times.
- States: FETCH, WAIT, EXEC, HALT, FAULT.
- FETCH:
  - If pc[1:0]!=0: io_imem_req_valid=0. Next state is FAULT with cause=1.
  - Otherwise io_imem_req_valid=1. When io_imem_req_ready=1 in the same cycle, the handshake completes and the next state is WAIT with the wait counter cleared.
  - Valid and addr hold stable while ready=0.
- WAIT:
  - io_imem_req_valid=0. The wait counter increments each cycle.
  - resp_valid with err=0: latch resp_data into io_instruction, go to EXEC.
  - resp_valid with err=1: go to FAULT with cause=2; io_instruction is unchanged.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with no response: go to FAULT with cause=3.
  - A response in the same cycle as the timeout wins.
- The earliest legal response is one cycle after the request handshake. resp_valid is ignored outside WAIT.
- EXEC:
  - io_inst_valid=1; the instruction is held stable.
  - On io_commit: pc<=io_pc_next, io_retired<=io_retired+1 (wraps modulo 2^32).
  - Next state is HALT if io_halt=1, else FETCH. The next request is issued the cycle after commit.
  - io_commit outside EXEC is ignored, with no pc or counter change.
- HALT: io_halted=1, no requests, terminal until reset.
- FAULT: io_fetch_fault=1, io_fault_cause holds its value, and pc holds the faulting address. No requests. Terminal until reset.
- io_inst_valid=0 in every state except EXEC.

Test Plan:
- Reset, req_ready=1, response 0x00000013 one cycle after handshake; commit with pc_next=0x80000004 → first request addr 0x80000000; inst_valid=1 with instruction 0x00000013 the cycle after the response; next request addr 0x80000004; io_retired=1.
- req_ready held low for 3 cycles → req_valid=1 and addr 0x80000000 stable throughout; no response accepted; handshake completes on cycle 4.
- Commit pc_next=0x80000002 → no further request; fault=1, cause=1, io_pc_count=0x80000002; a later io_commit has no effect.
- Response with err=1 → fault=1, cause=2, inst_valid never asserted. With TIMEOUT=4 and no response → cause=3 exactly 4 cycles after entering WAIT.
- Commit with halt=1 and pc_next=0x80000010 → halted=1, pc=0x80000010, req_valid stays 0 for 20 cycles.
- Reset pulsed mid-WAIT, then a stale resp_valid in the cycle reset deasserts → next request addr 0x80000000; stale response ignored; retired=0.

Source files
------------

// File: rtl/ysyx_25030077_ifu_if.sv
// Instruction-memory port between the fetch unit and memory.
// Request:  io_imem_req_valid / io_imem_req_ready / io_imem_req_addr
// Response: io_imem_resp_valid / io_imem_resp_data / io_imem_resp_err
// master = fetch unit side, slave = memory side.
interface ysyx_25030077_ifu_if;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready;
    logic [31:0] io_imem_req_addr;
    logic        io_imem_resp_valid;
    logic [31:0] io_imem_resp_data;
    logic        io_imem_resp_err;

    modport master (
        output io_imem_req_valid,
        output io_imem_req_addr,
        input  io_imem_req_ready,
        input  io_imem_resp_valid,
        input  io_imem_resp_data,
        input  io_imem_resp_err
    );

    modport slave (
        input  io_imem_req_valid,
        input  io_imem_req_addr,
        output io_imem_req_ready,
        output io_imem_resp_valid,
        output io_imem_resp_data,
        output io_imem_resp_err
    );
endinterface

// File: rtl/ysyx_25030077_ifu.sv
// Instruction fetch unit: holds the PC, fetches one instruction at a time
// over the imem port, presents it to execute and waits for commit.
// Ports:
//   clock, reset        - clock, synchronous active-high reset
//   imem                - instruction-memory request/response (master)
//   io_pc_next/commit/halt - commit information from execute
//   io_inst_valid, io_instruction, io_pc_count - fetched instruction and PC
//   io_fetch_fault, io_fault_cause, io_halted  - sticky status
//   io_retired          - committed instruction count
module ysyx_25030077_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    ysyx_25030077_ifu_if.master        imem,
    input  logic [31:0]                io_pc_next,
    input  logic                       io_commit,
    input  logic                       io_halt,
    output logic                       io_inst_valid,
    output logic [31:0]                io_instruction,
    output logic [31:0]                io_pc_count,
    output logic                       io_fetch_fault,
    output logic [1:0]                 io_fault_cause,
    output logic                       io_halted,
    output logic [31:0]                io_retired
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_WAIT  = 3'd1,
        S_EXEC  = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        r_instruction;
    logic [31:0]        r_retired;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   w_wait_cnt_inc;
    logic [1:0]         r_fault_cause;
    logic [1:0]         w_fault_cause_nxt;
    logic               w_aligned;
    logic               w_req_fire;
    logic               w_resp_ok;
    logic               w_commit;

    assign w_aligned      = (r_pc[1:0] == 2'b00);
    assign w_req_fire     = (r_state == S_FETCH) && w_aligned && imem.io_imem_req_ready;
    assign w_resp_ok      = (r_state == S_WAIT) && imem.io_imem_resp_valid && !imem.io_imem_resp_err;
    assign w_commit       = (r_state == S_EXEC) && io_commit;
    assign w_wait_cnt_inc = r_wait_cnt + CNT_W'(1);

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_state_nxt;
    end

    // Next-state and fault-cause selection; a response beats a same-cycle timeout
    always_comb begin
        w_state_nxt       = r_state;
        w_fault_cause_nxt = r_fault_cause;
        case (r_state)
            S_FETCH: begin
                if (!w_aligned) begin
                    w_state_nxt       = S_FAULT;
                    w_fault_cause_nxt = 2'd1;
                end else if (imem.io_imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.io_imem_resp_valid) begin
                    if (imem.io_imem_resp_err) begin
                        w_state_nxt       = S_FAULT;
                        w_fault_cause_nxt = 2'd2;
                    end else begin
                        w_state_nxt = S_EXEC;
                    end
                end else if ((TIMEOUT != 0) && (w_wait_cnt_inc == CNT_W'(TIMEOUT))) begin
                    w_state_nxt       = S_FAULT;
                    w_fault_cause_nxt = 2'd3;
                end
            end
            S_EXEC: begin
                if (io_commit) w_state_nxt = io_halt ? S_HALT : S_FETCH;
            end
            S_HALT:  w_state_nxt = S_HALT;
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Outputs decoded from state; request is suppressed while reset is held
    always_comb begin
        imem.io_imem_req_valid = !reset && (r_state == S_FETCH) && w_aligned;
        io_inst_valid          = (r_state == S_EXEC);
        io_fetch_fault         = (r_state == S_FAULT);
        io_halted              = (r_state == S_HALT);
    end

    // Datapath: PC, instruction latch, retire and wait counters, fault cause
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_instruction <= 32'h0;
            r_retired     <= 32'h0;
            r_wait_cnt    <= '0;
            r_fault_cause <= 2'd0;
        end else begin
            r_fault_cause <= w_fault_cause_nxt;
            if (w_req_fire)            r_wait_cnt <= '0;
            else if (r_state == S_WAIT) r_wait_cnt <= w_wait_cnt_inc;
            if (w_resp_ok) r_instruction <= imem.io_imem_resp_data;
            if (w_commit) begin
                r_pc      <= io_pc_next;
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign imem.io_imem_req_addr = r_pc;
    assign io_pc_count           = r_pc;
    assign io_instruction        = r_instruction;
    assign io_retired            = r_retired;
    assign io_fault_cause        = r_fault_cause;

endmodule

// File: tb/tb_ysyx_25030077_ifu.sv
module tb_ysyx_25030077_ifu;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] io_pc_next;
    logic        io_commit;
    logic        io_halt;
    logic        io_inst_valid;
    logic [31:0] io_instruction;
    logic [31:0] io_pc_count;
    logic        io_fetch_fault;
    logic [1:0]  io_fault_cause;
    logic        io_halted;
    logic [31:0] io_retired;
    int          checks   = 0;
    int          failures = 0;

    ysyx_25030077_ifu_if imem ();

    ysyx_25030077_ifu #(.RESET_PC(32'h8000_0000), .TIMEOUT(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .imem          (imem),
        .io_pc_next    (io_pc_next),
        .io_commit     (io_commit),
        .io_halt       (io_halt),
        .io_inst_valid (io_inst_valid),
        .io_instruction(io_instruction),
        .io_pc_count   (io_pc_count),
        .io_fetch_fault(io_fetch_fault),
        .io_fault_cause(io_fault_cause),
        .io_halted     (io_halted),
        .io_retired    (io_retired)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        io_pc_next = 32'h0; io_commit = 1'b0; io_halt = 1'b0;
        imem.io_imem_req_ready = 1'b0; imem.io_imem_resp_valid = 1'b0;
        imem.io_imem_resp_data = 32'h0; imem.io_imem_resp_err = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    // Fetch one instruction (handshake + response) and commit it
    task automatic fetch_commit(input logic [31:0] data, input logic [31:0] nxt, input logic halt);
        imem.io_imem_req_ready = 1'b1; step();
        imem.io_imem_req_ready = 1'b0;
        imem.io_imem_resp_valid = 1'b1; imem.io_imem_resp_data = data; step();
        imem.io_imem_resp_valid = 1'b0;
        io_commit = 1'b1; io_pc_next = nxt; io_halt = halt; step();
        io_commit = 1'b0; io_halt = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step(); step();
        checks++; if (imem.io_imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", imem.io_imem_req_valid); end
        reset = 1'b0;
        #1;
        checks++; if (io_pc_count !== 32'h8000_0000) begin failures++; $display("FAIL rst_pc got=%h exp=80000000", io_pc_count); end
        checks++; if (io_instruction !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", io_instruction); end
        checks++; if (io_retired !== 32'h0) begin failures++; $display("FAIL rst_retired got=%h exp=0", io_retired); end
        checks++; if ({io_inst_valid, io_fetch_fault, io_fault_cause, io_halted} !== 5'b0) begin failures++;
            $display("FAIL rst_status got=%b%b%b%b exp=00000", io_inst_valid, io_fetch_fault, io_fault_cause, io_halted); end
        checks++; if (imem.io_imem_req_valid !== 1'b1 || imem.io_imem_req_addr !== 32'h8000_0000) begin failures++;
            $display("FAIL rst_first_req got=%b/%h exp=1/80000000", imem.io_imem_req_valid, imem.io_imem_req_addr); end
    endtask

    task automatic test_basic_fetch();
        do_reset();
        imem.io_imem_req_ready = 1'b1; step();
        imem.io_imem_req_ready = 1'b0;
        checks++; if (imem.io_imem_req_valid !== 1'b0) begin failures++; $display("FAIL wait_req_valid got=%b exp=0", imem.io_imem_req_valid); end
        imem.io_imem_resp_valid = 1'b1; imem.io_imem_resp_data = 32'h0000_0013; step();
        imem.io_imem_resp_valid = 1'b0;
        checks++; if (io_inst_valid !== 1'b1 || io_instruction !== 32'h0000_0013) begin failures++;
            $display("FAIL exec_inst got=%b/%h exp=1/00000013", io_inst_valid, io_instruction); end
        io_commit = 1'b1; io_pc_next = 32'h8000_0004; step();
        io_commit = 1'b0;
        checks++; if (imem.io_imem_req_valid !== 1'b1 || imem.io_imem_req_addr !== 32'h8000_0004) begin failures++;
            $display("FAIL next_req got=%b/%h exp=1/80000004", imem.io_imem_req_valid, imem.io_imem_req_addr); end
        checks++; if (io_retired !== 32'd1 || io_inst_valid !== 1'b0) begin failures++;
            $display("FAIL retired1 got=%0d/%b exp=1/0", io_retired, io_inst_valid); end
    endtask

    task automatic test_back_to_back();
        fetch_commit(32'h0010_0093, 32'h8000_0008, 1'b0);
        checks++; if (io_instruction !== 32'h0010_0093 || io_pc_count !== 32'h8000_0008 || io_retired !== 32'd2) begin failures++;
            $display("FAIL b2b got=%h/%h/%0d exp=00100093/80000008/2", io_instruction, io_pc_count, io_retired); end
    endtask

    task automatic test_ready_stall();
        do_reset();
        imem.io_imem_resp_valid = 1'b1; imem.io_imem_resp_data = 32'hDEAD_BEEF;
        io_commit = 1'b1; io_pc_next = 32'h8000_0100;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (imem.io_imem_req_valid !== 1'b1 || imem.io_imem_req_addr !== 32'h8000_0000) begin failures++;
                $display("FAIL stall_req cyc=%0d got=%b/%h exp=1/80000000", i, imem.io_imem_req_valid, imem.io_imem_req_addr); end
        end
        checks++; if (io_inst_valid !== 1'b0 || io_instruction !== 32'h0 || io_retired !== 32'h0 || io_pc_count !== 32'h8000_0000) begin failures++;
            $display("FAIL stall_ignored got=%b/%h/%0d/%h exp=0/0/0/80000000", io_inst_valid, io_instruction, io_retired, io_pc_count); end
        clear_inputs();
        imem.io_imem_req_ready = 1'b1; step();
        imem.io_imem_req_ready = 1'b0;
        checks++; if (imem.io_imem_req_valid !== 1'b0 || io_fetch_fault !== 1'b0) begin failures++;
            $display("FAIL stall_handshake got=%b/%b exp=0/0", imem.io_imem_req_valid, io_fetch_fault); end
    endtask

    task automatic test_misaligned();
        do_reset();
        fetch_commit(32'h0000_0013, 32'h8000_0002, 1'b0);
        checks++; if (imem.io_imem_req_valid !== 1'b0) begin failures++; $display("FAIL mis_req got=%b exp=0", imem.io_imem_req_valid); end
        step();
        checks++; if (io_fetch_fault !== 1'b1 || io_fault_cause !== 2'd1 || io_pc_count !== 32'h8000_0002) begin failures++;
            $display("FAIL mis_fault got=%b/%0d/%h exp=1/1/80000002", io_fetch_fault, io_fault_cause, io_pc_count); end
        io_commit = 1'b1; io_pc_next = 32'h8000_0100; step(); step();
        io_commit = 1'b0;
        checks++; if (io_pc_count !== 32'h8000_0002 || io_retired !== 32'd1 || io_fault_cause !== 2'd1 || imem.io_imem_req_valid !== 1'b0) begin failures++;
            $display("FAIL mis_commit_ignored got=%h/%0d/%0d/%b exp=80000002/1/1/0", io_pc_count, io_retired, io_fault_cause, imem.io_imem_req_valid); end
    endtask

    task automatic test_bus_error();
        do_reset();
        imem.io_imem_req_ready = 1'b1; step();
        imem.io_imem_req_ready = 1'b0;
        imem.io_imem_resp_valid = 1'b1; imem.io_imem_resp_err = 1'b1; imem.io_imem_resp_data = 32'hCAFE_F00D; step();
        clear_inputs();
        checks++; if (io_fetch_fault !== 1'b1 || io_fault_cause !== 2'd2 || io_inst_valid !== 1'b0 || io_instruction !== 32'h0) begin failures++;
            $display("FAIL bus_err got=%b/%0d/%b/%h exp=1/2/0/0", io_fetch_fault, io_fault_cause, io_inst_valid, io_instruction); end
    endtask

    task automatic test_timeout();
        do_reset();
        imem.io_imem_req_ready = 1'b1; step();
        imem.io_imem_req_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (io_fetch_fault !== 1'b0) begin failures++; $display("FAIL tmo_early cyc=%0d got=%b exp=0", i, io_fetch_fault); end
        end
        step();
        checks++; if (io_fetch_fault !== 1'b1 || io_fault_cause !== 2'd3 || io_pc_count !== 32'h8000_0000) begin failures++;
            $display("FAIL tmo_fault got=%b/%0d/%h exp=1/3/80000000", io_fetch_fault, io_fault_cause, io_pc_count); end
    endtask

    task automatic test_timeout_race();
        do_reset();
        imem.io_imem_req_ready = 1'b1; step();
        imem.io_imem_req_ready = 1'b0;
        step(); step(); step();
        imem.io_imem_resp_valid = 1'b1; imem.io_imem_resp_data = 32'h0000_0073; step();
        clear_inputs();
        checks++; if (io_inst_valid !== 1'b1 || io_fetch_fault !== 1'b0 || io_instruction !== 32'h0000_0073) begin failures++;
            $display("FAIL tmo_race got=%b/%b/%h exp=1/0/00000073", io_inst_valid, io_fetch_fault, io_instruction); end
    endtask

    task automatic test_halt();
        do_reset();
        fetch_commit(32'h0010_0073, 32'h8000_0010, 1'b1);
        checks++; if (io_halted !== 1'b1 || io_pc_count !== 32'h8000_0010 || io_retired !== 32'd1) begin failures++;
            $display("FAIL halt got=%b/%h/%0d exp=1/80000010/1", io_halted, io_pc_count, io_retired); end
        imem.io_imem_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++; if (imem.io_imem_req_valid !== 1'b0 || io_halted !== 1'b1) begin failures++;
                $display("FAIL halt_idle cyc=%0d got=%b/%b exp=0/1", i, imem.io_imem_req_valid, io_halted); end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        fetch_commit(32'h0000_0013, 32'h8000_0004, 1'b0);
        imem.io_imem_req_ready = 1'b1; step();
        imem.io_imem_req_ready = 1'b0;
        reset = 1'b1; step();
        checks++; if (imem.io_imem_req_valid !== 1'b0) begin failures++; $display("FAIL midrst_req got=%b exp=0", imem.io_imem_req_valid); end
        reset = 1'b0;
        imem.io_imem_resp_valid = 1'b1; imem.io_imem_resp_data = 32'h5555_5555; step();
        imem.io_imem_resp_valid = 1'b0;
        checks++; if (imem.io_imem_req_valid !== 1'b1 || imem.io_imem_req_addr !== 32'h8000_0000) begin failures++;
            $display("FAIL midrst_req_addr got=%b/%h exp=1/80000000", imem.io_imem_req_valid, imem.io_imem_req_addr); end
        checks++; if (io_inst_valid !== 1'b0 || io_instruction !== 32'h0 || io_retired !== 32'h0) begin failures++;
            $display("FAIL midrst_stale got=%b/%h/%0d exp=0/0/0", io_inst_valid, io_instruction, io_retired); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_back_to_back();
        test_ready_stall();
        test_misaligned();
        test_bus_error();
        test_timeout();
        test_timeout_race();
        test_halt();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
